// File: rtl/des_pkg.sv
// Shared constants and types for the DES key-schedule slice: PC-1 index maps,
// per-round left-shift table, FSM state encoding and half-key rotate helpers.
package des_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned ROUNDS = 16;
  localparam int unsigned RN_W   = 4;

  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // DES bit numbers (1 = MSB of the key) feeding C bits 1..28 and D bits 1..28
  localparam logic [6:0] PC1_C [HALF_W] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36
  };

  localparam logic [6:0] PC1_D [HALF_W] = '{
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // Entry i is the left shift applied to reach round i+1
  localparam logic [1:0] SHIFTS [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_t rotl28(input half_t x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                         : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic half_t rotr28(input half_t x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                         : {x[0], x[HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_permutation_1.sv
// Combinational PC-1: drops the eight parity bits and splits the key into
// the 28-bit C and D halves.
module des_permutation_1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] i_key,
  output half_t            o_c,
  output half_t            o_d
);

  // DES bit n lives at i_key[64-n]; half bit n lives at o_x[28-n]
  always_comb begin
    o_c = '0;
    o_d = '0;
    for (int unsigned j = 0; j < HALF_W; j++) begin
      o_c[5'(HALF_W - 1 - j)] = i_key[6'(KEY_W - 32'(PC1_C[j]))];
      o_d[5'(HALF_W - 1 - j)] = i_key[6'(KEY_W - 32'(PC1_D[j]))];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: emits the 16 (C_i, D_i) pairs in encrypt or
// decrypt order over a valid/ready port. Define DES_KEY_PARITY_CHECK_EN to
// enable the advisory per-byte odd-parity flag on parity_err.
module des_key_schedule
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key,
  input  logic              decrypt,
  output logic              round_valid,
  input  logic              round_ready,
  output logic [RN_W-1:0]   round_num,
  output logic              round_last,
  output logic [HALF_W-1:0] c_out,
  output logic [HALF_W-1:0] d_out,
  output logic              parity_err
);

  state_t          r_state, w_state_nxt;
  logic            r_decrypt, w_decrypt_nxt;
  logic            r_round_valid, w_round_valid_nxt;
  logic [RN_W-1:0] r_round_num, w_round_num_nxt;
  half_t           r_c, r_d, w_c_nxt, w_d_nxt;
  half_t           w_pc1_c, w_pc1_d;
  logic [RN_W-1:0] w_rn_inc;
  logic [1:0]      w_shamt;

  des_permutation_1 u_pc1 (
    .i_key (key),
    .o_c   (w_pc1_c),
    .o_d   (w_pc1_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_decrypt     <= 1'b0;
      r_round_valid <= 1'b0;
      r_round_num   <= '0;
      r_c           <= '0;
      r_d           <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_decrypt     <= w_decrypt_nxt;
      r_round_valid <= w_round_valid_nxt;
      r_round_num   <= w_round_num_nxt;
      r_c           <= w_c_nxt;
      r_d           <= w_d_nxt;
    end
  end

  // Decrypt walks the shift table backwards: reaching pair k undoes shift[17-k]
  always_comb begin
    w_state_nxt       = r_state;
    w_decrypt_nxt     = r_decrypt;
    w_round_valid_nxt = r_round_valid;
    w_round_num_nxt   = r_round_num;
    w_c_nxt           = r_c;
    w_d_nxt           = r_d;
    key_ready         = 1'b0;
    w_rn_inc          = r_round_num + 4'd1;
    w_shamt           = r_decrypt ? SHIFTS[4'(5'd16 - {1'b0, w_rn_inc})]
                                  : SHIFTS[w_rn_inc];
    case (r_state)
      S_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          w_state_nxt       = S_RUN;
          w_decrypt_nxt     = decrypt;
          w_round_valid_nxt = 1'b1;
          w_round_num_nxt   = '0;
          w_c_nxt           = decrypt ? w_pc1_c : rotl28(w_pc1_c, SHIFTS[0]);
          w_d_nxt           = decrypt ? w_pc1_d : rotl28(w_pc1_d, SHIFTS[0]);
        end
      end
      S_RUN: begin
        if (round_ready) begin
          if (r_round_num == RN_W'(ROUNDS - 1)) begin
            w_state_nxt       = S_IDLE;
            w_round_valid_nxt = 1'b0;
          end else begin
            w_round_num_nxt = w_rn_inc;
            w_c_nxt = r_decrypt ? rotr28(r_c, w_shamt) : rotl28(r_c, w_shamt);
            w_d_nxt = r_decrypt ? rotr28(r_d, w_shamt) : rotl28(r_d, w_shamt);
          end
        end
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_round_valid_nxt = 1'b0;
      end
    endcase
  end

  assign round_valid = r_round_valid;
  assign round_num   = r_round_num;
  assign round_last  = (r_state == S_RUN) && (r_round_num == RN_W'(ROUNDS - 1));
  assign c_out       = r_c;
  assign d_out       = r_d;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic       r_parity_err;
  logic [7:0] w_byte_par;

  // Odd parity per byte is expected; any even byte raises the flag
  always_comb begin
    w_byte_par = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      w_byte_par[3'(i >> 3)] = w_byte_par[3'(i >> 3)] ^ key[6'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if ((r_state == S_IDLE) && key_valid) begin
      r_parity_err <= ~(&w_byte_par);
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus pushes expected pairs,
// a negedge monitor pops and compares on every round handshake.
`timescale 1ns/1ps
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        round_valid;
  logic        round_ready = 1'b1;
  logic [3:0]  round_num;
  logic        round_last;
  logic [27:0] c_out, d_out;
  logic        parity_err;

  des_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key         (key),
    .decrypt     (decrypt),
    .round_valid (round_valid),
    .round_ready (round_ready),
    .round_num   (round_num),
    .round_last  (round_last),
    .c_out       (c_out),
    .d_out       (d_out),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_B   = 64'h0123456789ABCDEF;
  localparam logic [27:0] C0 = 28'b1111000011001100101010101111;
  localparam logic [27:0] D0 = 28'b0101010101100110011110001111;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic EXP_PAR_BAD = 1'b1;
`else
  localparam logic EXP_PAR_BAD = 1'b0;
`endif

  typedef struct {
    logic [3:0]  rn;
    logic        last;
    logic [27:0] c;
    logic [27:0] d;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_hs  = 0;
  logic        rdy_rand = 1'b0;
  logic [27:0] tc [17];
  logic [27:0] td [17];
  int          sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [27:0] rl(input logic [27:0] x, input int n);
    return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    round_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_exp(input logic dec);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.rn   = 4'(k);
      e.last = (k == 15);
      e.c    = dec ? tc[16-k] : tc[k+1];
      e.d    = dec ? td[16-k] : td[k+1];
      q.push_back(e);
    end
  endtask

  task automatic load(input logic [63:0] k, input logic dec);
    int g = 0;
    while (!key_ready && g < 200) begin
      step();
      g++;
    end
    chk("key_ready_before_load", 64'(key_ready), 64'd1);
    key       = k;
    decrypt   = dec;
    key_valid = 1'b1;
    push_exp(dec);
    step();
    key_valid = 1'b0;
  endtask

  task automatic run_to_idle(output int cycles);
    cycles = 0;
    while (!key_ready && cycles < 2000) begin
      step();
      cycles++;
    end
    chk("idle_reached", 64'(key_ready), 64'd1);
  endtask

  // Monitor: stall stability, busy key_ready, and scoreboard pops
  logic        held = 1'b0;
  logic [27:0] hc, hd;
  logic [3:0]  hrn;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !round_valid) begin
      held = 1'b0;
    end else begin
      chk("key_ready_busy", 64'(key_ready), 64'd0);
      if (held) begin
        chk("stall_c", 64'(c_out), 64'(hc));
        chk("stall_d", 64'(d_out), 64'(hd));
        chk("stall_rn", 64'(round_num), 64'(hrn));
      end
      if (round_ready) begin
        n_hs++;
        held = 1'b0;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pair: got rn %0d with empty scoreboard", round_num);
        end else begin
          e = q.pop_front();
          chk("round_num", 64'(round_num), 64'(e.rn));
          chk("round_last", 64'(round_last), 64'(e.last));
          chk("c_out", 64'(c_out), 64'(e.c));
          chk("d_out", 64'(d_out), 64'(e.d));
        end
      end else begin
        held = 1'b1;
        hc   = c_out;
        hd   = d_out;
        hrn  = round_num;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    chk({tag, "_round_valid"}, 64'(round_valid), 64'd0);
    chk({tag, "_round_num"}, 64'(round_num), 64'd0);
    chk({tag, "_round_last"}, 64'(round_last), 64'd0);
    chk({tag, "_c_out"}, 64'(c_out), 64'd0);
    chk({tag, "_d_out"}, 64'(d_out), 64'd0);
    chk({tag, "_parity_err"}, 64'(parity_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hs0;
    int g;

    tc[0] = C0;
    td[0] = D0;
    for (int i = 1; i <= 16; i++) begin
      tc[i] = rl(tc[i-1], sh[i-1]);
      td[i] = rl(td[i-1], sh[i-1]);
    end

    #12;
    chk_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Encrypt, ready tied high: 16 back-to-back pairs
    hs0 = n_hs;
    load(KEY_A, 1'b0);
    chk("enc_first_valid", 64'(round_valid), 64'd1);
    chk("enc_first_rn", 64'(round_num), 64'd0);
    chk("enc_first_c", 64'(c_out), 64'(28'b1110000110011001010101011111));
    chk("enc_first_d", 64'(d_out), 64'(28'b1010101011001100111100011110));
    run_to_idle(cyc);
    chk("enc_cycles", 64'(cyc), 64'd16);
    chk("enc_handshakes", 64'(n_hs - hs0), 64'd16);
    chk("enc_last_c_is_c0", 64'(c_out), 64'(C0));
    chk("enc_last_d_is_d0", 64'(d_out), 64'(D0));
    chk("enc_parity", 64'(parity_err), 64'd0);

    // Decrypt: reverse order, first pair is C0/D0
    hs0 = n_hs;
    load(KEY_A, 1'b1);
    chk("dec_first_c", 64'(c_out), 64'(C0));
    chk("dec_first_d", 64'(d_out), 64'(D0));
    run_to_idle(cyc);
    chk("dec_cycles", 64'(cyc), 64'd16);
    chk("dec_handshakes", 64'(n_hs - hs0), 64'd16);

    // Backpressure with pseudo-random round_ready
    rdy_rand = 1'b1;
    hs0 = n_hs;
    load(KEY_A, 1'b0);
    run_to_idle(cyc);
    chk("bp_handshakes", 64'(n_hs - hs0), 64'd16);
    rdy_rand = 1'b0;
    round_ready = 1'b1;
    step();

    // key_valid held during RUN with another key must be ignored
    hs0 = n_hs;
    load(KEY_A, 1'b0);
    key       = KEY_B;
    decrypt   = 1'b1;
    key_valid = 1'b1;
    g = 0;
    while (round_num != 4'd15 && g < 100) begin
      step();
      g++;
    end
    chk("ignore_reach_r16", 64'(round_num), 64'd15);
    key_valid = 1'b0;
    run_to_idle(cyc);
    chk("ignore_handshakes", 64'(n_hs - hs0), 64'd16);
    step();
    chk("ignore_no_reload", 64'(round_valid), 64'd0);

    // Reset mid-sequence at round 7
    load(KEY_A, 1'b0);
    g = 0;
    while (round_num != 4'd6 && g < 100) begin
      step();
      g++;
    end
    chk("mid_reach_r7", 64'(round_num), 64'd6);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    step();
    rst_n = 1'b1;
    step();
    hs0 = n_hs;
    load(KEY_A, 1'b0);
    chk("restart_rn", 64'(round_num), 64'd0);
    run_to_idle(cyc);
    chk("restart_handshakes", 64'(n_hs - hs0), 64'd16);

    // Parity flag: bad key then good key
    load(KEY_BAD, 1'b0);
    chk("parity_bad_key", 64'(parity_err), 64'(EXP_PAR_BAD));
    run_to_idle(cyc);
    chk("parity_bad_hold", 64'(parity_err), 64'(EXP_PAR_BAD));
    load(KEY_A, 1'b0);
    chk("parity_good_key", 64'(parity_err), 64'd0);
    run_to_idle(cyc);

    step();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
